// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder: ID word plus RW words, with one waitrequest-low accept cycle per access.
// Optional saturating error counter on o_err_cnt when AVMM_CSR_RESPONDER_ERR_CNT_EN is defined.
module avmm_csr_responder #(
    parameter int               AVMM_ADDR_W   = 13,
    parameter int               DATA_W        = 32,
    parameter int               NUM_REGS      = 8,
    parameter int               ADDR_BASE     = 0,
    parameter int               WAIT_CYCLES   = 2,
    parameter logic [DATA_W-1:0] ID_VALUE      = 32'h4D4D5253,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = 32'hDEADBEEF
) (
    input  logic                         i_avmm_clk,
    input  logic                         i_avmm_rst_n,
    input  logic [AVMM_ADDR_W-1:0]       i_avmm_addr,
    input  logic                         i_avmm_read,
    input  logic                         i_avmm_write,
    input  logic [DATA_W-1:0]            i_avmm_writedata,
    output logic [DATA_W-1:0]            o_avmm_readdata,
    output logic                         o_avmm_readdata_valid,
    output logic                         o_avmm_waitrequest,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    output logic [NUM_REGS-1:0]          o_wr_pulse
`ifdef AVMM_CSR_RESPONDER_ERR_CNT_EN
    ,
    output logic [7:0]                   o_err_cnt
`endif
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int XW    = AVMM_ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACCEPT, S_DRAIN} state_t;

    state_t                         state;
    logic [3:0]                     cnt;
    logic [AVMM_ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]              wdata_q;
    logic                           op_rd_q;
    logic                           wr_drop_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    logic [AVMM_ADDR_W-1:0] dec_addr;
    logic [XW-1:0]          idx;
    logic [IDX_W-1:0]       idx_lo;
    logic                   in_range;
    logic [DATA_W-1:0]      rd_val;
    logic                   wr_commit;
    logic                   err_evt;

    // Decode the live address in IDLE (zero-wait accept) and the latched one otherwise.
    always_comb begin
        dec_addr  = (state == S_IDLE) ? i_avmm_addr : addr_q;
        idx       = {1'b0, dec_addr} - XW'(ADDR_BASE);
        in_range  = ~idx[XW-1] && (idx < XW'(NUM_REGS));
        idx_lo    = idx[IDX_W-1:0];
        rd_val    = DEFAULT_RDATA;
        if (in_range)
            rd_val = (idx == '0) ? ID_VALUE : regs[idx_lo];
        wr_commit = (state == S_ACCEPT) && !op_rd_q && in_range && (idx != '0);
        err_evt   = (state == S_ACCEPT) &&
                    (!in_range || wr_drop_q || (!op_rd_q && (idx == '0)));
    end

    always_ff @(posedge i_avmm_clk or negedge i_avmm_rst_n) begin
        if (!i_avmm_rst_n) begin
            state                 <= S_IDLE;
            cnt                   <= '0;
            addr_q                <= '0;
            wdata_q               <= '0;
            op_rd_q               <= 1'b0;
            wr_drop_q             <= 1'b0;
            regs                  <= '0;
            o_avmm_readdata       <= '0;
            o_avmm_readdata_valid <= 1'b0;
            o_avmm_waitrequest    <= 1'b1;
            o_wr_pulse            <= '0;
        end else begin
            o_wr_pulse <= '0;
            case (state)
                S_IDLE: if (i_avmm_read || i_avmm_write) begin
                    addr_q    <= i_avmm_addr;
                    wdata_q   <= i_avmm_writedata;
                    op_rd_q   <= i_avmm_read;
                    wr_drop_q <= i_avmm_read & i_avmm_write;
                    if (WAIT_CYCLES == 0) begin
                        state                 <= S_ACCEPT;
                        o_avmm_waitrequest    <= 1'b0;
                        o_avmm_readdata_valid <= i_avmm_read;
                        if (i_avmm_read) o_avmm_readdata <= rd_val;
                    end else begin
                        state <= S_BUSY;
                        cnt   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                S_BUSY: if (cnt == '0) begin
                    state                 <= S_ACCEPT;
                    o_avmm_waitrequest    <= 1'b0;
                    o_avmm_readdata_valid <= op_rd_q;
                    if (op_rd_q) o_avmm_readdata <= rd_val;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_ACCEPT: begin
                    state                 <= S_DRAIN;
                    o_avmm_waitrequest    <= 1'b1;
                    o_avmm_readdata_valid <= 1'b0;
                    if (wr_commit) begin
                        regs[idx_lo]       <= wdata_q;
                        o_wr_pulse[idx_lo] <= 1'b1;
                    end
                end
                S_DRAIN: if (!i_avmm_read && !i_avmm_write) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_regs = regs;

`ifdef AVMM_CSR_RESPONDER_ERR_CNT_EN
    // Writing the last word clears the count; that takes priority over an increment.
    always_ff @(posedge i_avmm_clk or negedge i_avmm_rst_n) begin
        if (!i_avmm_rst_n)
            o_err_cnt <= '0;
        else if (wr_commit && (idx_lo == IDX_W'(NUM_REGS - 1)))
            o_err_cnt <= '0;
        else if (err_evt && (o_err_cnt != 8'hFF))
            o_err_cnt <= o_err_cnt + 8'd1;
    end
`endif
endmodule
